// File: rtl/alarm_set_ctrl.sv
// Alarm-time setting controller: three debounced keys drive an
// IDLE -> SET_HOUR -> SET_MIN editor with auto-repeat, timeout and blink.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   key_mode          : raw active-low mode button
//   key_inc, key_dec  : raw active-low step buttons
//   adjust_clock_num  : committed alarm time, BCD {H10,H1,M10,M1}
//   edit_num          : shadow time being edited (equals committed in IDLE)
//   alarm_en          : alarm armed flag, toggled by inc in IDLE
//   set_state         : 00 IDLE, 01 SET_HOUR, 10 SET_MIN
//   blink             : blink for the field being edited

// One key: 2-flop synchronizer, symmetric debounce, press pulse and
// auto-repeat pulses while held (only when rep_en).
module alarm_set_ctrl_key #(
    parameter int DEB_CYCLES    = 960000,
    parameter int REPEAT_DELAY  = 48000000,
    parameter int REPEAT_PERIOD = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    input  logic rep_en,
    output logic press,
    output logic rep
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [1:0]    sync;
    logic          low;
    logic          held;
    logic          deb_hit;
    logic [DW-1:0] deb_cnt;
    logic          armed;
    logic          first;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_lim;

    assign low     = ~sync[1];
    assign deb_hit = (low != held) && (deb_cnt == DW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key};
        end
    end

    // deb_cnt counts consecutive cycles the synchronized level disagrees
    // with the accepted state; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held    <= 1'b0;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            press <= deb_hit & low;
            if (low != held) begin
                if (deb_hit) begin
                    held    <= low;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Repeat only after a press accepted while enabled; the first
    // interval is the long delay, later ones the short period.
    assign rep_lim = first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rep     = armed & held & rep_en & ~press & (rep_cnt == rep_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            first   <= 1'b1;
            rep_cnt <= '0;
        end else if (!rep_en || !held) begin
            armed   <= 1'b0;
            first   <= 1'b1;
            rep_cnt <= '0;
        end else if (press) begin
            armed   <= 1'b1;
            first   <= 1'b1;
            rep_cnt <= '0;
        end else if (rep) begin
            first   <= 1'b0;
            rep_cnt <= '0;
        end else if (armed) begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end
endmodule

module alarm_set_ctrl #(
    parameter int DEB_CYCLES    = 960000,
    parameter int REPEAT_DELAY  = 48000000,
    parameter int REPEAT_PERIOD = 12000000,
    parameter int TIMEOUT       = 480000000,
    parameter int BLINK_HALF    = 12000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic        key_dec,
    output logic [15:0] adjust_clock_num,
    output logic [15:0] edit_num,
    output logic        alarm_en,
    output logic [1:0]  set_state,
    output logic        blink
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_HOUR = 2'b01;
    localparam logic [1:0] S_MIN  = 2'b10;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    logic [1:0]    state;
    logic [15:0]   shadow;
    logic [15:0]   next_shadow;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] blink_cnt;
    logic [2:0]    press;
    logic [2:0]    rep;
    logic          in_set;
    logic          up;
    logic          dn;
    logic          act;
    logic          to_hit;

    assign in_set = (state != S_IDLE);

    // bit 0 mode (never repeats), bit 1 inc, bit 2 dec
    alarm_set_ctrl_key #(
        .DEB_CYCLES(DEB_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_mode (
        .clk(clk), .rst_n(rst_n), .key(key_mode), .rep_en(1'b0),
        .press(press[0]), .rep(rep[0])
    );

    alarm_set_ctrl_key #(
        .DEB_CYCLES(DEB_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_inc (
        .clk(clk), .rst_n(rst_n), .key(key_inc), .rep_en(in_set),
        .press(press[1]), .rep(rep[1])
    );

    alarm_set_ctrl_key #(
        .DEB_CYCLES(DEB_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_dec (
        .clk(clk), .rst_n(rst_n), .key(key_dec), .rep_en(in_set),
        .press(press[2]), .rep(rep[2])
    );

    function automatic logic [7:0] hour_step(input logic [7:0] h,
                                             input logic inc);
        logic [7:0] r;
        if (inc) begin
            if (h == 8'h23)            r = 8'h00;
            else if (h[3:0] == 4'd9)   r = {h[7:4] + 4'd1, 4'd0};
            else                       r = {h[7:4], h[3:0] + 4'd1};
        end else begin
            if (h == 8'h00)            r = 8'h23;
            else if (h[3:0] == 4'd0)   r = {h[7:4] - 4'd1, 4'd9};
            else                       r = {h[7:4], h[3:0] - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] min_step(input logic [7:0] m,
                                            input logic inc);
        logic [7:0] r;
        if (inc) begin
            if (m == 8'h59)            r = 8'h00;
            else if (m[3:0] == 4'd9)   r = {m[7:4] + 4'd1, 4'd0};
            else                       r = {m[7:4], m[3:0] + 4'd1};
        end else begin
            if (m == 8'h00)            r = 8'h59;
            else if (m[3:0] == 4'd0)   r = {m[7:4] - 4'd1, 4'd9};
            else                       r = {m[7:4], m[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Simultaneous inc and dec cancel; mode wins over both.
    always_comb begin
        up          = (press[1] | rep[1]) & ~(press[2] | rep[2]) & ~press[0];
        dn          = (press[2] | rep[2]) & ~(press[1] | rep[1]) & ~press[0];
        act         = (|press) | (|rep);
        to_hit      = in_set & ~act & (to_cnt == TW'(TIMEOUT - 1));
        next_shadow = shadow;
        if (state == S_HOUR) begin
            next_shadow[15:8] = hour_step(shadow[15:8], up);
        end else begin
            next_shadow[7:0]  = min_step(shadow[7:0], up);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            shadow           <= 16'h0700;
            adjust_clock_num <= 16'h0700;
            alarm_en         <= 1'b0;
            blink            <= 1'b0;
            blink_cnt        <= '0;
            to_cnt           <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    shadow    <= adjust_clock_num;
                    to_cnt    <= '0;
                    blink_cnt <= '0;
                    if (press[0]) begin
                        state <= S_HOUR;
                        blink <= 1'b1;
                    end else begin
                        blink <= 1'b0;
                        if (press[1]) alarm_en <= ~alarm_en;
                    end
                end
                S_HOUR, S_MIN: begin
                    if (to_hit) begin
                        state     <= S_IDLE;
                        shadow    <= adjust_clock_num;
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= act ? '0 : to_cnt + TW'(1);
                        if (press[0]) begin
                            blink_cnt <= '0;
                            if (state == S_HOUR) begin
                                state <= S_MIN;
                                blink <= 1'b1;
                            end else begin
                                state            <= S_IDLE;
                                adjust_clock_num <= shadow;
                                blink            <= 1'b0;
                            end
                        end else if (up | dn) begin
                            shadow    <= next_shadow;
                            blink     <= 1'b1;
                            blink_cnt <= '0;
                        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                            blink     <= ~blink;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign edit_num  = shadow;
    assign set_state = state;
endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: table of key presses with expected
// outputs, plus hand sequences for glitches, repeat, blink, timeout, reset.
module tb_alarm_set_ctrl;
    localparam int OP_MODE = 0;
    localparam int OP_INC  = 1;
    localparam int OP_DEC  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_mode = 1'b1;
    logic        key_inc = 1'b1;
    logic        key_dec = 1'b1;
    logic [15:0] adj;
    logic [15:0] ed;
    logic        en;
    logic [1:0]  st;
    logic        blink;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          op;
        int          cnt;
        logic [1:0]  st;
        logic [15:0] adj;
        logic [15:0] ed;
        logic        en;
    } vec_t;

    vec_t tbl[19];

    alarm_set_ctrl #(
        .DEB_CYCLES(4),
        .REPEAT_DELAY(40),
        .REPEAT_PERIOD(10),
        .TIMEOUT(200),
        .BLINK_HALF(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_mode(key_mode),
        .key_inc(key_inc),
        .key_dec(key_dec),
        .adjust_clock_num(adj),
        .edit_num(ed),
        .alarm_en(en),
        .set_state(st),
        .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int op, input logic v);
        case (op)
            OP_MODE: key_mode = v;
            OP_INC:  key_inc = v;
            default: key_dec = v;
        endcase
    endtask

    task automatic press(input int op, input int n);
        for (int i = 0; i < n; i++) begin
            drive(op, 1'b0);
            tick(8);
            drive(op, 1'b1);
            tick(8);
        end
    endtask

    task automatic chk_out(input string nm, input logic [1:0] e_st,
                           input logic [15:0] e_adj,
                           input logic [15:0] e_ed, input logic e_en);
        @(negedge clk);
        chk({nm, ".state"}, {14'd0, st}, {14'd0, e_st});
        chk({nm, ".adj"}, adj, e_adj);
        chk({nm, ".edit"}, ed, e_ed);
        chk({nm, ".en"}, {15'd0, en}, {15'd0, e_en});
    endtask

    initial begin
        int k;
        tbl[0]  = '{OP_INC,  1, 2'd0, 16'h0700, 16'h0700, 1'b1};
        tbl[1]  = '{OP_INC,  1, 2'd0, 16'h0700, 16'h0700, 1'b0};
        tbl[2]  = '{OP_DEC,  1, 2'd0, 16'h0700, 16'h0700, 1'b0};
        tbl[3]  = '{OP_MODE, 1, 2'd1, 16'h0700, 16'h0700, 1'b0};
        tbl[4]  = '{OP_INC,  3, 2'd1, 16'h0700, 16'h1000, 1'b0};
        tbl[5]  = '{OP_MODE, 1, 2'd2, 16'h0700, 16'h1000, 1'b0};
        tbl[6]  = '{OP_DEC,  1, 2'd2, 16'h0700, 16'h1059, 1'b0};
        tbl[7]  = '{OP_MODE, 1, 2'd0, 16'h1059, 16'h1059, 1'b0};
        tbl[8]  = '{OP_MODE, 1, 2'd1, 16'h1059, 16'h1059, 1'b0};
        tbl[9]  = '{OP_DEC, 10, 2'd1, 16'h1059, 16'h0059, 1'b0};
        tbl[10] = '{OP_DEC,  1, 2'd1, 16'h1059, 16'h2359, 1'b0};
        tbl[11] = '{OP_INC,  1, 2'd1, 16'h1059, 16'h0059, 1'b0};
        tbl[12] = '{OP_DEC,  1, 2'd1, 16'h1059, 16'h2359, 1'b0};
        tbl[13] = '{OP_MODE, 1, 2'd2, 16'h1059, 16'h2359, 1'b0};
        tbl[14] = '{OP_INC,  1, 2'd2, 16'h1059, 16'h2300, 1'b0};
        tbl[15] = '{OP_DEC,  1, 2'd2, 16'h1059, 16'h2359, 1'b0};
        tbl[16] = '{OP_DEC,  1, 2'd2, 16'h1059, 16'h2358, 1'b0};
        tbl[17] = '{OP_MODE, 1, 2'd0, 16'h2358, 16'h2358, 1'b0};
        tbl[18] = '{OP_INC,  1, 2'd0, 16'h2358, 16'h2358, 1'b1};

        // reset state
        repeat (2) @(negedge clk);
        chk_out("reset", 2'd0, 16'h0700, 16'h0700, 1'b0);
        chk("reset.blink", {15'd0, blink}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 19; i++) begin
            press(tbl[i].op, tbl[i].cnt);
            chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].adj,
                    tbl[i].ed, tbl[i].en);
        end

        // glitches shorter than the debounce time give no step
        press(OP_MODE, 1);
        chk_out("glitch.enter", 2'd1, 16'h2358, 16'h2358, 1'b1);
        key_inc = 1'b0; tick(2); key_inc = 1'b1; tick(10);
        chk_out("glitch2", 2'd1, 16'h2358, 16'h2358, 1'b1);
        key_inc = 1'b0; tick(3); key_inc = 1'b1; tick(10);
        chk_out("glitch3", 2'd1, 16'h2358, 16'h2358, 1'b1);
        key_inc = 1'b0; tick(4); key_inc = 1'b1; tick(12);
        chk_out("low4", 2'd1, 16'h2358, 16'h0058, 1'b1);

        // inc+dec together cancel
        key_inc = 1'b0; key_dec = 1'b0; tick(8);
        key_inc = 1'b1; key_dec = 1'b1; tick(10);
        chk_out("incdec", 2'd1, 16'h2358, 16'h0058, 1'b1);

        // mode+inc together: mode wins
        key_mode = 1'b0; key_inc = 1'b0; tick(8);
        key_mode = 1'b1; key_inc = 1'b1; tick(10);
        chk_out("modeinc", 2'd2, 16'h2358, 16'h0058, 1'b1);

        // asynchronous reset mid-edit
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rst.state", {14'd0, st}, 16'd0);
        chk("rst.adj", adj, 16'h0700);
        chk("rst.edit", ed, 16'h0700);
        chk("rst.en", {15'd0, en}, 16'd0);
        chk("rst.blink", {15'd0, blink}, 16'd0);

        // key held through reset release needs a full debounce
        key_inc = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        chk_out("held.early", 2'd0, 16'h0700, 16'h0700, 1'b0);
        tick(6);
        chk_out("held.late", 2'd0, 16'h0700, 16'h0700, 1'b1);
        key_inc = 1'b1;
        tick(10);
        chk("idle.blink", {15'd0, blink}, 16'd0);

        // blink pattern after SET entry
        drive(OP_MODE, 1'b0);
        k = 0;
        while (st !== 2'b01 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("blink.enter", {14'd0, st}, 16'd1);
        for (int j = 0; j <= 16; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 0 || j == 7 || j == 16)
                chk($sformatf("blink%0d", j), {15'd0, blink}, 16'd1);
            if (j == 8 || j == 15)
                chk($sformatf("blink%0d", j), {15'd0, blink}, 16'd0);
        end
        drive(OP_MODE, 1'b1);
        tick(10);

        // timeout in SET_MIN discards the edit
        press(OP_MODE, 1);
        chk_out("to.min", 2'd2, 16'h0700, 16'h0700, 1'b1);
        press(OP_INC, 1);
        chk_out("to.edit", 2'd2, 16'h0700, 16'h0701, 1'b1);
        tick(150);
        chk_out("to.before", 2'd2, 16'h0700, 16'h0701, 1'b1);
        tick(60);
        chk_out("to.after", 2'd0, 16'h0700, 16'h0700, 1'b1);

        // auto-repeat: first step, repeats at +40, +50, +60
        press(OP_MODE, 1);
        chk_out("rep.enter", 2'd1, 16'h0700, 16'h0700, 1'b1);
        drive(OP_INC, 1'b0);
        k = 0;
        while (ed === 16'h0700 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rep.first", ed, 16'h0800);
        for (int j = 1; j <= 80; j++) begin
            @(negedge clk);
            if (j == 39) chk("rep.k39", ed, 16'h0800);
            if (j == 40) chk("rep.k40", ed, 16'h0900);
            if (j == 55) begin
                chk("rep.k55", ed, 16'h1000);
                key_inc = 1'b1;
            end
            if (j == 80) chk("rep.k80", ed, 16'h1100);
        end
        chk("rep.state", {14'd0, st}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
